time_set_ctrl: RTL and testbench

//  Digital-clock core: keeps hours/minutes/seconds and runs the user time-setting FSM.

---
 rtl/time_set_ctrl_pkg.sv | 14 +
 rtl/time_set_ctrl_mod_counter.sv | 33 +++
 rtl/time_set_ctrl.sv | 112 +++++++++++
 tb/tb_time_set_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the digital-clock core: set-state encodings and field widths.
package time_set_ctrl_pkg;

  localparam int HR_W = 5;
  localparam int MS_W = 6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_RSVD    = 2'b11
  } set_state_t;

endpackage

// File: rtl/time_set_ctrl_mod_counter.sv
// Modulo-(MAX+1) up/down counter used for the seconds, minutes and hours fields.
// wrap flags an increment at (or, defensively, above) MAX so the next field can carry.
module mod_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  localparam logic [W-1:0] MAX_Q = W'(MAX);

  assign wrap = inc && (q >= MAX_Q);

  // Field register: clear beats inc, inc beats dec; both directions wrap within 0..MAX.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q >= MAX_Q) ? '0 : q + W'(1);
    end else if (dec) begin
      q <= ((q == '0) || (q > MAX_Q)) ? MAX_Q : q - W'(1);
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Digital-clock core: hours/minutes/seconds keeping plus the user time-setting FSM
// and the blink enables for the display encoder. All outputs come from registers.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int HOUR_MAX = 23,
  parameter int MIN_MAX  = 59,
  parameter int SEC_MAX  = 59
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            tick_1hz,
  input  logic            mode_pulse,
  input  logic            inc_pulse,
  input  logic            dec_pulse,
  output logic [HR_W-1:0] hours,
  output logic [MS_W-1:0] minutes,
  output logic [MS_W-1:0] seconds,
  output logic [1:0]      set_state,
  output logic            blink_hr,
  output logic            blink_min
);

  set_state_t state_q, state_d;
  logic       phase_q, phase_d;
  logic       sec_inc, sec_clr;
  logic       min_inc, min_dec;
  logic       hr_inc, hr_dec;
  logic       sec_wrap, min_wrap, hr_wrap_unused;
  logic       edit_inc, edit_dec;

  // inc wins over dec when both buttons pulse in the same cycle.
  assign edit_inc = inc_pulse;
  assign edit_dec = dec_pulse & ~inc_pulse;

  mod_counter #(.W(MS_W), .MAX(SEC_MAX)) u_sec (
    .CLK(CLK), .RST(RST), .inc(sec_inc), .dec(1'b0), .clr(sec_clr),
    .q(seconds), .wrap(sec_wrap)
  );

  mod_counter #(.W(MS_W), .MAX(MIN_MAX)) u_min (
    .CLK(CLK), .RST(RST), .inc(min_inc), .dec(min_dec), .clr(1'b0),
    .q(minutes), .wrap(min_wrap)
  );

  mod_counter #(.W(HR_W), .MAX(HOUR_MAX)) u_hr (
    .CLK(CLK), .RST(RST), .inc(hr_inc), .dec(hr_dec), .clr(1'b0),
    .q(hours), .wrap(hr_wrap_unused)
  );

  // Next state, counter steering and blink phase; mode has priority over inc/dec.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    sec_inc = 1'b0;
    sec_clr = 1'b0;
    min_inc = 1'b0;
    min_dec = 1'b0;
    hr_inc  = 1'b0;
    hr_dec  = 1'b0;
    case (state_q)
      ST_RUN: begin
        // Timekeeping continues even on the edge that enters SET_HR.
        sec_inc = tick_1hz;
        min_inc = sec_wrap;
        hr_inc  = min_wrap;
        if (mode_pulse) state_d = ST_SET_HR;
      end
      ST_SET_HR: begin
        if (mode_pulse) begin
          state_d = ST_SET_MIN;
        end else begin
          hr_inc = edit_inc;
          hr_dec = edit_dec;
          if (edit_inc || edit_dec) phase_d = 1'b1;
          else if (tick_1hz)        phase_d = ~phase_q;
        end
      end
      ST_SET_MIN: begin
        if (mode_pulse) begin
          state_d = ST_RUN;
          sec_clr = 1'b1;
        end else begin
          min_inc = edit_inc;
          min_dec = edit_dec;
          if (edit_inc || edit_dec) phase_d = 1'b1;
          else if (tick_1hz)        phase_d = ~phase_q;
        end
      end
      default: state_d = ST_RUN;
    endcase
    if (state_d != state_q) phase_d = 1'b1;
  end

  // State, phase and the registered blink enables derived from their next values.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= ST_RUN;
      phase_q   <= 1'b1;
      blink_hr  <= 1'b1;
      blink_min <= 1'b1;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      blink_hr  <= (state_d != ST_SET_HR)  | phase_d;
      blink_min <= (state_d != ST_SET_MIN) | phase_d;
    end
  end

  assign set_state = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios plus randomized button/tick traffic,
// a time-of-day reference model and a per-cycle scoreboard.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0, mode = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] set_state;
  logic       blink_hr, blink_min;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int h, m, s, st;
    bit bh, bm;
  } exp_t;

  exp_t sb[$];

  // reference model state: st 0=RUN 1=SET_HR 2=SET_MIN
  int m_h = 0, m_m = 0, m_s = 0, m_st = 0;
  bit m_ph = 1'b1;

  time_set_ctrl #(.HOUR_MAX(23), .MIN_MAX(59), .SEC_MAX(59)) dut (
    .CLK(clk), .RST(rst_n), .tick_1hz(tick), .mode_pulse(mode),
    .inc_pulse(inc), .dec_pulse(dec), .hours(hours), .minutes(minutes),
    .seconds(seconds), .set_state(set_state), .blink_hr(blink_hr),
    .blink_min(blink_min)
  );

  always #5 clk = ~clk;

  function automatic void cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // advance time of day by one second, as seconds-since-midnight arithmetic
  task automatic advance_second();
    int total;
    total = ((m_h * 60 + m_m) * 60 + m_s + 1) % 86400;
    m_h = total / 3600;
    m_m = (total / 60) % 60;
    m_s = total % 60;
  endtask

  task automatic model(input bit r, input bit t, input bit mo, input bit i, input bit d);
    if (!r) begin
      m_h = 0; m_m = 0; m_s = 0; m_st = 0; m_ph = 1'b1;
    end else if (mo) begin
      if (m_st == 0 && t) advance_second();
      if (m_st == 2) m_s = 0;
      m_st = (m_st + 1) % 3;
      m_ph = 1'b1;
    end else if (m_st == 0) begin
      if (t) advance_second();
    end else begin
      if (i || d) begin
        if (m_st == 1) m_h = i ? (m_h + 1) % 24 : (m_h + 23) % 24;
        else           m_m = i ? (m_m + 1) % 60 : (m_m + 59) % 60;
        m_ph = 1'b1;
      end else if (t) begin
        m_ph = ~m_ph;
      end
    end
  endtask

  task automatic step(input bit r, input bit t, input bit mo, input bit i, input bit d);
    exp_t e;
    @(negedge clk);
    rst_n = r; tick = t; mode = mo; inc = i; dec = d;
    model(r, t, mo, i, d);
    e.h = m_h; e.m = m_m; e.s = m_s; e.st = m_st;
    e.bh = (m_st != 1) || m_ph;
    e.bm = (m_st != 2) || m_ph;
    sb.push_back(e);
  endtask

  // directed check against hand-written constants, after the pending edge
  task automatic check_now(input string nm, input int h, input int m, input int s,
                           input int st, input bit bh, input bit bm);
    @(posedge clk);
    #2;
    cmp({nm, ".hours"}, 32'(hours), h);
    cmp({nm, ".minutes"}, 32'(minutes), m);
    cmp({nm, ".seconds"}, 32'(seconds), s);
    cmp({nm, ".set_state"}, 32'(set_state), st);
    cmp({nm, ".blink_hr"}, 32'(blink_hr), 32'(bh));
    cmp({nm, ".blink_min"}, 32'(blink_min), 32'(bm));
  endtask

  // monitor: every edge presents a fresh output set, compare it with the queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("sb.hours", 32'(hours), e.h);
      cmp("sb.minutes", 32'(minutes), e.m);
      cmp("sb.seconds", 32'(seconds), e.s);
      cmp("sb.set_state", 32'(set_state), e.st);
      cmp("sb.blink_hr", 32'(blink_hr), 32'(e.bh));
      cmp("sb.blink_min", 32'(blink_min), 32'(e.bm));
    end
  end

  initial begin
    // 1 reset
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check_now("reset", 0, 0, 0, 0, 1, 1);

    // 2 preload 23:59 via set mode, then roll over
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    check_now("hr_dec_wrap", 23, 0, 0, 1, 1, 1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0);
    check_now("preload", 23, 59, 0, 0, 1, 1);
    repeat (59) step(1, 1, 0, 0, 0);
    check_now("pre_roll", 23, 59, 59, 0, 1, 1);
    step(1, 1, 0, 0, 0);
    check_now("rollover", 0, 0, 0, 0, 1, 1);

    // 3 set-mode wraps
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    check_now("set_hr_dec", 23, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 0);
    check_now("set_hr_inc", 0, 0, 0, 1, 1, 1);
    repeat (7) step(1, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1);
    check_now("set_min_dec", 7, 59, 0, 2, 1, 1);
    step(1, 0, 0, 1, 0);
    check_now("set_min_wrap", 7, 0, 0, 2, 1, 1);

    // 4 freeze and exit
    step(1, 0, 1, 0, 0);
    repeat (3) step(1, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (5) step(1, 1, 0, 0, 0);
    check_now("freeze", 7, 0, 3, 2, 1, 0);
    step(1, 0, 1, 0, 0);
    check_now("exit_clr", 7, 0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0);
    check_now("resume", 7, 0, 1, 0, 1, 1);

    // 5 simultaneous inputs
    step(1, 0, 1, 1, 0);
    check_now("mode_inc", 7, 0, 1, 1, 1, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 1, 1);
    check_now("inc_dec", 6, 0, 1, 1, 1, 1);
    step(1, 1, 0, 0, 0);
    check_now("blink_off", 6, 0, 1, 1, 0, 1);
    step(1, 1, 0, 1, 0);
    check_now("tick_inc", 7, 0, 1, 1, 1, 1);

    // 6 blink sequence and reset mid-set
    step(1, 1, 0, 0, 0);
    check_now("blink1", 7, 0, 1, 1, 0, 1);
    step(1, 1, 0, 0, 0);
    check_now("blink2", 7, 0, 1, 1, 1, 1);
    step(1, 1, 0, 0, 0);
    check_now("blink3", 7, 0, 1, 1, 0, 1);
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check_now("reset_mid_set", 0, 0, 0, 0, 1, 1);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bit r, t, mo, i, d;
      r  = ($urandom_range(0, 299) != 0);
      t  = ($urandom_range(0, 3) == 0);
      mo = ($urandom_range(0, 19) == 0);
      i  = ($urandom_range(0, 4) == 0);
      d  = ($urandom_range(0, 4) == 0);
      step(r, t, mo, i, d);
    end
    step(1, 0, 0, 0, 0);

    for (int w = 0; w < 20 && sb.size() > 0; w++) @(posedge clk);
    #3;
    cmp("drain", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
